// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one single-port memory bus between instruction fetch (IF) and data (MEM); data wins.
// Latency: bus request registered one cycle after the port request; result in DONE state, min 3 cycles/access.
// Backpressure: per-port stall requests stay high until that port's DONE cycle; no preemption.
//
// Ports:
//   clk, rst             core clock, asynchronous active-low reset
//   if_ce_i/if_addr_i    fetch request; if_data_o/if_stallreq_o fetch response and stall
//   mem_ce_i/we/sel/addr/data_i  data request; mem_data_o/mem_stallreq_o data response and stall
//   bus_req/we/sel/addr/wdata_o  registered memory bus request, held stable while waiting
//   bus_rdata_i/bus_ack_i        memory response (single-cycle ack)
//   bus_err_o                    one-cycle pulse when a transaction times out
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {IDLE, DWAIT, IWAIT, DDONE, IDONE} state_t;

  // Counter value of the last wait cycle before abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bus_req_nxt, bus_we_nxt, bus_err_nxt;
  logic [3:0]       bus_sel_nxt;
  logic [31:0]      bus_addr_nxt, bus_wdata_nxt;
  logic [31:0]      if_data_nxt, mem_data_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
      if_data_o   <= '0;
      mem_data_o  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bus_req_o   <= bus_req_nxt;
      bus_we_o    <= bus_we_nxt;
      bus_sel_o   <= bus_sel_nxt;
      bus_addr_o  <= bus_addr_nxt;
      bus_wdata_o <= bus_wdata_nxt;
      bus_err_o   <= bus_err_nxt;
      if_data_o   <= if_data_nxt;
      mem_data_o  <= mem_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus_req_nxt   = bus_req_o;
    bus_we_nxt    = bus_we_o;
    bus_sel_nxt   = bus_sel_o;
    bus_addr_nxt  = bus_addr_o;
    bus_wdata_nxt = bus_wdata_o;
    bus_err_nxt   = 1'b0;
    if_data_nxt   = if_data_o;
    mem_data_nxt  = mem_data_o;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (mem_ce_i) begin
          state_nxt     = DWAIT;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = mem_we_i;
          bus_sel_nxt   = mem_sel_i;
          bus_addr_nxt  = mem_addr_i;
          bus_wdata_nxt = mem_we_i ? mem_data_i : 32'h0;
        end else if (if_ce_i) begin
          state_nxt     = IWAIT;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = 1'b0;
          bus_sel_nxt   = 4'b1111;
          bus_addr_nxt  = if_addr_i;
          bus_wdata_nxt = 32'h0;
        end
      end

      DWAIT, IWAIT: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (bus_ack_i || cnt == CNT_LAST) begin
          cnt_nxt       = '0;
          bus_req_nxt   = 1'b0;
          bus_we_nxt    = 1'b0;
          bus_sel_nxt   = '0;
          bus_addr_nxt  = '0;
          bus_wdata_nxt = '0;
          bus_err_nxt   = !bus_ack_i;
          if (state == DWAIT) begin
            state_nxt = DDONE;
            // Stores return nothing: the load-data register is cleared.
            mem_data_nxt = (bus_ack_i && !bus_we_o) ? bus_rdata_i : 32'h0;
          end else begin
            state_nxt   = IDONE;
            if_data_nxt = bus_ack_i ? bus_rdata_i : 32'h0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DDONE, IDONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  // A port is released only during its own DONE cycle.
  assign mem_stallreq_o = mem_ce_i & (state != DDONE);
  assign if_stallreq_o  = if_ce_i  & (state != IDONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: directed self-checking bench for mem_bus_arbiter.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: bus_ack_i is driven by hand at known cycles; every wait is a fixed cycle count.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_stallreq_o(if_stallreq_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_stallreq_o(mem_stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    if_ce_i = 1'b0; if_addr_i = '0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
    tick(); tick();

    // Reset state
    check("rst_req",   32'(bus_req_o), 32'h0);
    check("rst_err",   32'(bus_err_o), 32'h0);
    check("rst_addr",  bus_addr_o, 32'h0);
    check("rst_ifd",   if_data_o, 32'h0);
    check("rst_memd",  mem_data_o, 32'h0);
    check("rst_istl0", 32'(if_stallreq_o), 32'h0);
    if_ce_i = 1'b1; if_addr_i = 32'h4;
    #1;
    check("rst_istl1", 32'(if_stallreq_o), 32'h1);
    tick();
    check("rst_hold",  32'(bus_req_o), 32'h0);
    rst = 1'b1;

    // 1: fetch only, ack in the second wait cycle
    tick();
    check("t1_req",   32'(bus_req_o), 32'h1);
    check("t1_sel",   32'(bus_sel_o), 32'hF);
    check("t1_addr",  bus_addr_o, 32'h4);
    check("t1_we",    32'(bus_we_o), 32'h0);
    check("t1_stl",   32'(if_stallreq_o), 32'h1);
    tick();
    check("t1_req2",  32'(bus_req_o), 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h24010005;
    tick();
    bus_ack_i = 1'b0;
    check("t1_stl_lo", 32'(if_stallreq_o), 32'h0);
    check("t1_data",   if_data_o, 32'h24010005);
    check("t1_reqlo",  32'(bus_req_o), 32'h0);
    tick();
    check("t1_stl_hi", 32'(if_stallreq_o), 32'h1);
    if_ce_i = 1'b0;
    tick();
    check("t1_idle",  32'(bus_req_o), 32'h0);

    // 6a: spurious ack in IDLE
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    tick();
    bus_ack_i = 1'b0;
    check("t6_ifd",   if_data_o, 32'h24010005);
    check("t6_memd",  mem_data_o, 32'h0);
    check("t6_req",   32'(bus_req_o), 32'h0);

    // 2: simultaneous requests, data first
    if_ce_i = 1'b1; if_addr_i = 32'h8;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h100;
    tick();
    check("t2_daddr", bus_addr_o, 32'h100);
    check("t2_dwe",   32'(bus_we_o), 32'h0);
    check("t2_mstl",  32'(mem_stallreq_o), 32'h1);
    check("t2_istl",  32'(if_stallreq_o), 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h11223344;
    tick();
    bus_ack_i = 1'b0;
    check("t2_mstl_lo", 32'(mem_stallreq_o), 32'h0);
    check("t2_istl_hi", 32'(if_stallreq_o), 32'h1);
    check("t2_memd",    mem_data_o, 32'h11223344);
    check("t2_reqlo",   32'(bus_req_o), 32'h0);
    mem_ce_i = 1'b0;
    tick();
    check("t2_gap",   32'(bus_req_o), 32'h0);
    tick();
    check("t2_ireq",  32'(bus_req_o), 32'h1);
    check("t2_iaddr", bus_addr_o, 32'h8);
    check("t2_isel",  32'(bus_sel_o), 32'hF);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hAABBCCDD;
    tick();
    check("t2_ifd",     if_data_o, 32'hAABBCCDD);
    check("t2_istl_lo", 32'(if_stallreq_o), 32'h0);
    // 6b: ack kept high through IDONE must be ignored
    bus_rdata_i = 32'h99999999;
    if_ce_i = 1'b0;
    tick();
    bus_ack_i = 1'b0;
    check("t6_done_ifd", if_data_o, 32'hAABBCCDD);
    check("t6_done_req", 32'(bus_req_o), 32'h0);

    // 3: store held stable until ack
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h200; mem_data_i = 32'hDEADBEEF;
    tick();
    check("t3_we",    32'(bus_we_o), 32'h1);
    check("t3_sel",   32'(bus_sel_o), 32'h3);
    check("t3_addr",  bus_addr_o, 32'h200);
    check("t3_wdata", bus_wdata_o, 32'hDEADBEEF);
    tick(); tick();
    check("t3_wdata_hold", bus_wdata_o, 32'hDEADBEEF);
    check("t3_we_hold",    32'(bus_we_o), 32'h1);
    check("t3_req_hold",   32'(bus_req_o), 32'h1);
    check("t3_mstl",       32'(mem_stallreq_o), 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
    tick();
    bus_ack_i = 1'b0;
    check("t3_mstl_lo", 32'(mem_stallreq_o), 32'h0);
    check("t3_memd",    mem_data_o, 32'h0);
    check("t3_we_lo",   32'(bus_we_o), 32'h0);
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_data_i = '0;
    tick();

    // 4: fetch with no ack times out after 16 wait cycles
    if_ce_i = 1'b1; if_addr_i = 32'hC;
    tick();
    check("t4_req", 32'(bus_req_o), 32'h1);
    for (int i = 0; i < 15; i++) begin
      check("t4_err_early", 32'(bus_err_o), 32'h0);
      tick();
    end
    check("t4_req_last", 32'(bus_req_o), 32'h1);
    check("t4_err_last", 32'(bus_err_o), 32'h0);
    tick();
    check("t4_err",    32'(bus_err_o), 32'h1);
    check("t4_ifd",    if_data_o, 32'h0);
    check("t4_stl_lo", 32'(if_stallreq_o), 32'h0);
    check("t4_reqlo",  32'(bus_req_o), 32'h0);
    tick();
    check("t4_err_lo", 32'(bus_err_o), 32'h0);
    check("t4_stl_hi", 32'(if_stallreq_o), 32'h1);
    tick();
    check("t4_retry_req",  32'(bus_req_o), 32'h1);
    check("t4_retry_addr", bus_addr_o, 32'hC);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    tick();
    bus_ack_i = 1'b0;
    check("t4_retry_ifd", if_data_o, 32'h12345678);
    if_ce_i = 1'b0;
    tick();

    // 5: async reset during DWAIT
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h300;
    tick();
    check("t5_req", 32'(bus_req_o), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_req_async", 32'(bus_req_o), 32'h0);
    check("t5_mstl",      32'(mem_stallreq_o), 32'h1);
    tick();
    rst = 1'b1;
    check("t5_err", 32'(bus_err_o), 32'h0);
    tick();
    check("t5_restart_req",  32'(bus_req_o), 32'h1);
    check("t5_restart_addr", bus_addr_o, 32'h300);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
    tick();
    bus_ack_i = 1'b0;
    check("t5_memd", mem_data_o, 32'h0BADF00D);
    check("t5_mstl_lo", 32'(mem_stallreq_o), 32'h0);
    mem_ce_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
